// File: rtl/esc_diff_responder.sv
// Receiving end of the differential escalation link.
// Decodes the esc_p/esc_n pair into ping or escalation and answers on the
// registered resp_p/resp_n pair. It also flags link integrity errors and
// optionally flags missing pings with a timeout counter.
module esc_diff_responder #(
    parameter int TimeoutCycles = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic esc_p_i,
    input  logic esc_n_i,
    output logic resp_p_o,
    output logic resp_n_o,
    output logic esc_req_o,
    output logic sigint_o,
    output logic timeout_o
);

    typedef enum logic [1:0] {
        Idle,
        Check,
        EscResp,
        SigInt
    } state_e;

    state_e state_q;

    logic act;
    logic inact;
    logic err;

    assign act   = esc_p_i & ~esc_n_i;
    assign inact = ~esc_p_i & esc_n_i;
    assign err   = ~(esc_p_i ^ esc_n_i);

    // Protocol FSM with registered response rails
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= Idle;
            resp_p_o <= 1'b0;
            resp_n_o <= 1'b1;
        end else begin
            unique case (state_q)
                Idle: begin
                    if (act) begin
                        state_q  <= Check;
                        resp_p_o <= 1'b1;
                        resp_n_o <= 1'b0;
                    end else if (err) begin
                        state_q  <= SigInt;
                        resp_p_o <= 1'b1;
                        resp_n_o <= 1'b1;
                    end else begin
                        resp_p_o <= 1'b0;
                        resp_n_o <= 1'b1;
                    end
                end
                Check: begin
                    if (act) begin
                        state_q  <= EscResp;
                        resp_p_o <= 1'b0;
                        resp_n_o <= 1'b1;
                    end else if (inact) begin
                        state_q  <= Idle;
                        resp_p_o <= 1'b0;
                        resp_n_o <= 1'b1;
                    end else begin
                        state_q  <= SigInt;
                        resp_p_o <= 1'b1;
                        resp_n_o <= 1'b1;
                    end
                end
                EscResp: begin
                    if (act) begin
                        // differential toggle: entry left (0,1), so (1,0) follows
                        resp_p_o <= ~resp_p_o;
                        resp_n_o <= resp_p_o;
                    end else if (inact) begin
                        state_q  <= Idle;
                        resp_p_o <= 1'b0;
                        resp_n_o <= 1'b1;
                    end else begin
                        state_q  <= SigInt;
                        resp_p_o <= 1'b1;
                        resp_n_o <= 1'b1;
                    end
                end
                SigInt: begin
                    if (err) begin
                        // common-mode toggle: entry left (1,1), so (0,0) follows
                        resp_p_o <= ~resp_p_o;
                        resp_n_o <= ~resp_p_o;
                    end else begin
                        state_q  <= Idle;
                        resp_p_o <= 1'b0;
                        resp_n_o <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= Idle;
                    resp_p_o <= 1'b0;
                    resp_n_o <= 1'b1;
                end
            endcase
        end
    end

    assign sigint_o  = (state_q == SigInt);
    assign esc_req_o = (state_q == EscResp) | (state_q == SigInt) | timeout_o;

    if (TimeoutCycles > 0) begin : g_timeout
        localparam int                CntW     = $clog2(TimeoutCycles + 1);
        localparam logic [CntW-1:0] Terminal = CntW'(TimeoutCycles - 1);

        logic [CntW-1:0] cnt_q;
        logic            armed_q;
        logic            timeout_q;
        logic            ping_done;
        logic            hold;

        assign ping_done = (state_q == Check) & inact;
        assign hold      = (state_q == EscResp) | (state_q == SigInt);

        // Ping watchdog: armed by the first completed ping, frozen during escalation
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q     <= '0;
                armed_q   <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                if (ping_done) begin
                    armed_q <= 1'b1;
                end
                if (armed_q && !timeout_q) begin
                    if (ping_done) begin
                        cnt_q <= '0;
                    end else if (!hold) begin
                        if (cnt_q == Terminal) begin
                            timeout_q <= 1'b1;
                        end else if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
            end
        end

        assign timeout_o = timeout_q;
    end else begin : g_no_timeout
        assign timeout_o = 1'b0;
    end

endmodule
